// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the word-address decoder.
// Latency: n/a (constants and a pure combinational function).
// Backpressure: n/a.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Decoder result: err flags any address outside the bank or not word
    // aligned; idx is the word index and only meaningful when err is 0.
    typedef struct packed {
        logic        err;
        logic [31:0] idx;
    } addr_dec_t;

    // Addresses arrive zero-extended to 64 bits so one function serves any
    // target address width. lsb is log2(bytes per word).
    function automatic addr_dec_t addr_decode(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned num_words,
        input int unsigned lsb
    );
        logic [63:0] off;
        logic [63:0] word;
        logic [63:0] lsb_mask;
        addr_dec_t   d;
        off      = addr - base;
        word     = off >> lsb;
        lsb_mask = (64'd1 << lsb) - 64'd1;
        d.idx    = word[31:0];
        d.err    = (addr < base) || (word >= 64'(num_words)) || ((off & lsb_mask) != 64'd0);
        return d;
    endfunction

endpackage

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder over a NUM_WORDS x DW flop register bank, full-word access only.
// Latency: B one cycle after the later of the AW/W handshakes; R one cycle after the AR handshake.
// Backpressure: AW/W stall while a B is pending, AR stalls while an R is pending; B and R are independent.
//
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   s_axi_lite_aw*           write address channel (awaddr/awvalid in, awready out)
//   s_axi_lite_w*            write data channel (wdata/wvalid in, wready out)
//   s_axi_lite_b*            write response channel (bresp/bvalid out, bready in)
//   s_axi_lite_ar*           read address channel (araddr/arvalid in, arready out)
//   s_axi_lite_r*            read data channel (rdata/rresp/rvalid out, rready in)
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int unsigned                AXI_WIDTH_ADDR = 32,
    parameter int unsigned                AXI_WIDTH_DATA = 32,
    parameter int unsigned                NUM_WORDS      = 16,
    parameter logic [AXI_WIDTH_ADDR-1:0]  BASE_ADDR      = '0
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [AXI_WIDTH_ADDR-1:0] s_axi_lite_awaddr,
    input  logic                      s_axi_lite_awvalid,
    output logic                      s_axi_lite_awready,

    input  logic [AXI_WIDTH_DATA-1:0] s_axi_lite_wdata,
    input  logic                      s_axi_lite_wvalid,
    output logic                      s_axi_lite_wready,

    output logic [1:0]                s_axi_lite_bresp,
    output logic                      s_axi_lite_bvalid,
    input  logic                      s_axi_lite_bready,

    input  logic [AXI_WIDTH_ADDR-1:0] s_axi_lite_araddr,
    input  logic                      s_axi_lite_arvalid,
    output logic                      s_axi_lite_arready,

    output logic [AXI_WIDTH_DATA-1:0] s_axi_lite_rdata,
    output logic [1:0]                s_axi_lite_rresp,
    output logic                      s_axi_lite_rvalid,
    input  logic                      s_axi_lite_rready
);

    localparam int unsigned AW  = AXI_WIDTH_ADDR;
    localparam int unsigned DW  = AXI_WIDTH_DATA;
    localparam int unsigned IW  = $clog2(NUM_WORDS);
    localparam int unsigned LSB = $clog2(DW / 8);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0] regs_q [NUM_WORDS];

    logic          aw_full_q;
    logic [AW-1:0] aw_q;
    logic          w_full_q;
    logic [DW-1:0] w_q;

    logic          bvalid_q;
    logic [1:0]    bresp_q;

    logic          rvalid_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;

    // ------------------------------------------------------------------
    // Handshakes (ready is a function of registered state only)
    // ------------------------------------------------------------------
    logic aw_hs, w_hs, ar_hs;
    logic aw_avail, w_avail, commit;

    assign s_axi_lite_awready = ~aw_full_q & ~bvalid_q;
    assign s_axi_lite_wready  = ~w_full_q  & ~bvalid_q;
    assign s_axi_lite_arready = ~rvalid_q;

    assign aw_hs = s_axi_lite_awvalid & s_axi_lite_awready;
    assign w_hs  = s_axi_lite_wvalid  & s_axi_lite_wready;
    assign ar_hs = s_axi_lite_arvalid & s_axi_lite_arready;

    assign aw_avail = aw_full_q | aw_hs;
    assign w_avail  = w_full_q  | w_hs;
    assign commit   = aw_avail & w_avail;

    // ------------------------------------------------------------------
    // Write decode: held address/data take priority over the live bus
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    addr_dec_t     wr_dec;
    logic          wr_err;
    logic [IW-1:0] wr_idx;

    assign wr_addr = aw_full_q ? aw_q : s_axi_lite_awaddr;
    assign wr_data = w_full_q  ? w_q  : s_axi_lite_wdata;
    assign wr_dec  = addr_decode(64'(wr_addr), 64'(BASE_ADDR), NUM_WORDS, LSB);
    // Upper index bits are already covered by err; folding them in keeps the
    // bank index provably in range even if the decoder bound changes.
    assign wr_err  = wr_dec.err | (|wr_dec.idx[31:IW]);
    assign wr_idx  = wr_dec.idx[IW-1:0];

    // ------------------------------------------------------------------
    // Read decode
    // ------------------------------------------------------------------
    addr_dec_t     rd_dec;
    logic          rd_err;
    logic [IW-1:0] rd_idx;

    assign rd_dec = addr_decode(64'(s_axi_lite_araddr), 64'(BASE_ADDR), NUM_WORDS, LSB);
    assign rd_err = rd_dec.err | (|rd_dec.idx[31:IW]);
    assign rd_idx = rd_dec.idx[IW-1:0];

    // ------------------------------------------------------------------
    // Write path: AW/W holding registers and B channel
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_full_q <= 1'b0;
            aw_q      <= '0;
            w_full_q  <= 1'b0;
            w_q       <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (bvalid_q && s_axi_lite_bready) begin
                bvalid_q <= 1'b0;
            end
            // A commit cannot coincide with a pending B: both readies are low
            // while bvalid is set, and two held entries never coexist.
            if (commit) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs) begin
                    aw_full_q <= 1'b1;
                    aw_q      <= s_axi_lite_awaddr;
                end
                if (w_hs) begin
                    w_full_q <= 1'b1;
                    w_q      <= s_axi_lite_wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit && !wr_err) begin
            regs_q[wr_idx] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read path: the bank is sampled before this edge's write lands, so a
    // same-edge read of the committing word returns the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_err ? '0 : regs_q[rd_idx];
            rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && s_axi_lite_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi_lite_bvalid = bvalid_q;
    assign s_axi_lite_bresp  = bresp_q;
    assign s_axi_lite_rvalid = rvalid_q;
    assign s_axi_lite_rdata  = rdata_q;
    assign s_axi_lite_rresp  = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
module tb_axi_lite_slave_regs;
    import axi_lite_pkg::*;

    logic        aclk;
    logic        aresetn;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_vec  = 0;
    int n_miss = 0;

    axi_lite_slave_regs #(
        .AXI_WIDTH_ADDR (32),
        .AXI_WIDTH_DATA (32),
        .NUM_WORDS      (16),
        .BASE_ADDR      (32'h0)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .s_axi_lite_awaddr  (awaddr),
        .s_axi_lite_awvalid (awvalid),
        .s_axi_lite_awready (awready),
        .s_axi_lite_wdata   (wdata),
        .s_axi_lite_wvalid  (wvalid),
        .s_axi_lite_wready  (wready),
        .s_axi_lite_bresp   (bresp),
        .s_axi_lite_bvalid  (bvalid),
        .s_axi_lite_bready  (bready),
        .s_axi_lite_araddr  (araddr),
        .s_axi_lite_arvalid (arvalid),
        .s_axi_lite_arready (arready),
        .s_axi_lite_rdata   (rdata),
        .s_axi_lite_rresp   (rresp),
        .s_axi_lite_rvalid  (rvalid),
        .s_axi_lite_rready  (rready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // AW and W presented together; B expected the cycle after both handshakes.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] exp_resp);
        int   n;
        logic a_ok, w_ok, ar_s, wr_s;
        n = 0; a_ok = 1'b0; w_ok = 1'b0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        while (!(a_ok && w_ok) && n < 20) begin
            ar_s = awready;
            wr_s = wready;
            tick();
            if (ar_s) begin a_ok = 1'b1; awvalid = 1'b0; end
            if (wr_s) begin w_ok = 1'b1; wvalid = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("write_accept", {31'b0, a_ok & w_ok}, 32'd1);
        check("write_bvalid", {31'b0, bvalid}, 32'd1);
        check("write_bresp", {30'b0, bresp}, {30'b0, exp_resp});
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("write_bdone", {31'b0, bvalid}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        arvalid = 1'b0;
        check("read_rvalid", {31'b0, rvalid}, 32'd1);
        d = rdata;
        r = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("read_rdone", {31'b0, rvalid}, 32'd0);
    endtask

    logic [31:0] rd;
    logic [1:0]  rr;

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 32'h0,        RESP_OKAY};
        vecs[1]  = '{1'b0, 32'h08, 32'h0,        32'hDEADBEEF, RESP_OKAY};
        vecs[2]  = '{1'b1, 32'h40, 32'h11111111, 32'h0,        RESP_SLVERR};
        vecs[3]  = '{1'b1, 32'h06, 32'h22222222, 32'h0,        RESP_SLVERR};
        vecs[4]  = '{1'b0, 32'h40, 32'h0,        32'h0,        RESP_SLVERR};
        vecs[5]  = '{1'b0, 32'h06, 32'h0,        32'h0,        RESP_SLVERR};
        vecs[6]  = '{1'b0, 32'h04, 32'h0,        32'h0,        RESP_OKAY};
        vecs[7]  = '{1'b0, 32'h3C, 32'h0,        32'h0,        RESP_OKAY};
        vecs[8]  = '{1'b1, 32'h3C, 32'hA5A5A5A5, 32'h0,        RESP_OKAY};
        vecs[9]  = '{1'b0, 32'h3C, 32'h0,        32'hA5A5A5A5, RESP_OKAY};
        vecs[10] = '{1'b0, 32'h00, 32'h0,        32'h0,        RESP_OKAY};
        vecs[11] = '{1'b0, 32'h08, 32'h0,        32'hDEADBEEF, RESP_OKAY};

        // Reset state
        tick();
        tick();
        aresetn = 1'b1;
        check("rst_bvalid",  {31'b0, bvalid},  32'd0);
        check("rst_rvalid",  {31'b0, rvalid},  32'd0);
        check("rst_awready", {31'b0, awready}, 32'd1);
        check("rst_wready",  {31'b0, wready},  32'd1);
        check("rst_arready", {31'b0, arready}, 32'd1);
        check("rst_rdata",   rdata,            32'd0);
        check("rst_bresp",   {30'b0, bresp},   32'd0);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_write) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_resp);
            end else begin
                do_read(vecs[i].addr, rd, rr);
                check("vec_rdata", rd, vecs[i].exp_data);
                check("vec_rresp", {30'b0, rr}, {30'b0, vecs[i].exp_resp});
            end
        end

        // W three cycles ahead of AW
        wdata = 32'h12345678; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wfirst_wready",  {31'b0, wready},  32'd0);
        check("wfirst_awready", {31'b0, awready}, 32'd1);
        check("wfirst_bvalid0", {31'b0, bvalid},  32'd0);
        tick();
        tick();
        check("wfirst_bvalid1", {31'b0, bvalid},  32'd0);
        awaddr = 32'h0C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_bvalid", {31'b0, bvalid}, 32'd1);
        check("wfirst_bresp",  {30'b0, bresp},  32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        do_read(32'h0C, rd, rr);
        check("wfirst_rdata", rd, 32'h12345678);

        // B stalled for five cycles; reads continue meanwhile
        awaddr = 32'h10; wdata = 32'h00000055; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid",  {31'b0, bvalid},  32'd1);
            check("stall_bresp",   {30'b0, bresp},   32'd0);
            check("stall_awready", {31'b0, awready}, 32'd0);
            check("stall_wready",  {31'b0, wready},  32'd0);
            if (i == 0) begin
                do_read(32'h08, rd, rr);
                check("stall_rdata", rd, 32'hDEADBEEF);
                check("stall_rresp", {30'b0, rr}, 32'd0);
            end else begin
                tick();
            end
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("stall_bdone", {31'b0, bvalid}, 32'd0);
        do_read(32'h10, rd, rr);
        check("stall_wdata", rd, 32'h00000055);

        // Same-edge write commit and read of the same word
        do_write(32'h0C, 32'h1, RESP_OKAY);
        awaddr = 32'h0C; wdata = 32'h2; araddr = 32'h0C;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("race_rvalid", {31'b0, rvalid}, 32'd1);
        check("race_rdata",  rdata,           32'h1);
        check("race_bvalid", {31'b0, bvalid}, 32'd1);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        do_read(32'h0C, rd, rr);
        check("race_followup", rd, 32'h2);

        // Reset with a held W and an unconsumed R
        araddr = 32'h08; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("rst2_rvalid_pre", {31'b0, rvalid}, 32'd1);
        wdata = 32'hCAFEF00D; wvalid = 1'b1;
        tick();
        check("rst2_wheld", {31'b0, wready}, 32'd0);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        wvalid = 1'b0;
        check("rst2_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst2_bvalid", {31'b0, bvalid}, 32'd0);
        check("rst2_wready", {31'b0, wready}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), rd, rr);
            check("rst2_reg_zero", rd, 32'h0);
        end
        // An AW alone must not pair with the W dropped by reset
        awaddr = 32'h00; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst2_no_b", {31'b0, bvalid}, 32'd0);
            tick();
        end
        check("rst2_awheld", {31'b0, awready}, 32'd0);
        wdata = 32'h00000077; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("rst2_bvalid_after_w", {31'b0, bvalid}, 32'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        do_read(32'h00, rd, rr);
        check("rst2_final_rdata", rd, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
